sram_responder: RTL and testbench
=================================

# sram_responder

Responder-side model of the external 1Mx16 asynchronous-style SRAM that the SLC-3 memory path drives through its active-low CE/UB/LB/OE/WE strobes, 20-bit ADDR and 16-bit data. It backs the CPU memory subsystem with on-chip storage. It is used for simulation and as an on-chip substitute for the board SRAM. It provides configurable read latency, byte-lane writes, an out-of-range window, and a side-band loader for program images.

## Interface
- DEPTH, 4096: number of 16-bit words implemented, addresses 0..DEPTH-1, power of two, max 65536.
- READ_LAT, 2: read latency in clocks, legal 1..4.
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high; clears pipeline/flags, not memory array.
- CE  in  1  chip enable, active-low.
- UB  in  1  upper byte lane [15:8] enable, active-low.
- LB  in  1  lower byte lane [7:0] enable, active-low.
- OE  in  1  output enable (read strobe), active-low.
- WE  in  1  write enable, active-low; dominates OE.
- ADDR  in  20  word address.
- Data_in  in  16  write data (tristate read side from CPU).
- Data_out  out  16  read data toward tristate.
- Data_oe  out  1  high while Data_out is valid and must be driven.
- Init_en  in  1  loader write strobe, active-high.
- Init_addr  in  16  loader word address.
- Init_data  in  16  loader word.
- Range_err  out  1  sticky: any CPU access hit ADDR >= DEPTH.
- Acc_count  out  16  count of accepted CPU accesses (reads+writes), wraps.

## Operation
- Per-edge decode when not in reset:
  - WRITE: CE=0, WE=0. WE wins over OE.
  - READ: CE=0, WE=1, OE=0.
  - IDLE: otherwise.
- WRITE, in range: lane [15:8] updated from Data_in[15:8] iff UB=0; lane [7:0] updated iff LB=0. With UB=LB=1 nothing is written, but the access is still counted.
- READ, in range: array word captured at the sampling edge. Disabled lanes are returned as 8'h00.
- Out of range (ADDR >= DEPTH, including any nonzero ADDR[19:16]):
  - write dropped;
  - read returns 16'h0000 with Data_oe asserted normally;
  - Range_err set to 1 until Reset.
- Read pipeline:
  - READ_LAT-stage shift of {valid, data}.
  - One read may enter per cycle; full throughput, in-order results.
  - An SLC-3 read state holding OE low for several cycles issues one read per cycle. All of them return the same word unless ADDR changes.
- Data_out holds the last delivered read value when no result is valid. Data_oe equals the output-stage valid bit.
- Loader: Init_en=1 writes Init_data to Init_addr (full 16 bits) if Init_addr < DEPTH, otherwise it is ignored.
  - Loader writes do not touch Range_err or Acc_count.
  - Init_en and a CPU WRITE to the same word in the same edge: loader value wins.
  - Different words: both are written.
- Acc_count increments by 1 on every READ or WRITE edge, in or out of range. It wraps FFFF->0000.

## Timing
- Reset asserted (asynchronous):
  - Data_out=16'h0000, Data_oe=0, Range_err=0, Acc_count=0.
  - All pipeline valid bits cleared; in-flight reads are discarded and never appear.
  - Memory array retains contents.
- Reset released: first decode at the next rising edge.
- READ sampled at edge t: Data_out/Data_oe valid after edge t+READ_LAT-1, i.e. READ_LAT=1 gives valid in the cycle directly after the request cycle.
- WRITE sampled at edge t: new data is visible to a READ sampled at edge t+1 or later. No same-edge read/write exists because WE dominates.
- Loader write at edge t is visible to a READ sampled at edge t+1.
- Range_err rises after the edge that samples the offending access.
- Acc_count updates after the edge that samples the access.

## Test plan
- Reset mid-read (READ_LAT=3): read of 0x0010 sampled, then Reset pulsed one cycle later -> Data_oe stays 0, Data_out=0000, value never emerges; memory word at 0x0010 unchanged afterward.
- Load then read: Init_en writes 0x1234 to 0x0005; CPU read 0x0005 with UB=LB=0, READ_LAT=2 -> Data_out=1234, Data_oe=1 exactly after the second edge; Acc_count=1.
- Byte lanes: word 0x0007=0xAAAA; write 0x5566 with UB=1, LB=0 -> read returns AA66. Then read with LB=1 -> 0xAA00.
- WE dominance and back-to-back: edge t CE=0, WE=0, OE=0 writes 0xBEEF to 0x0002; edges t+1..t+3 reads of 0x0002, 0x0003, 0x0002 -> three consecutive valid cycles BEEF, old[3], BEEF in order; Acc_count=4.
- Out of range (DEPTH=4096): write 0x1111 to ADDR=0x01000, then read the same address -> Data_out=0000 with Data_oe=1, Range_err=1 sticky; word 0x000 unaffected.
- Collision and wrap: Init_en and CPU write both target 0x0009 (Init 0x7777, CPU 0x8888) -> read gives 7777. Preload Acc_count to FFFF via 65535 accesses, one more access -> 0000.

Source files
------------

// File: rtl/sram_responder.sv
// sram_responder
// Responder-side model of a 1Mx16 asynchronous-style SRAM with active-low
// strobes, backed by DEPTH words of on-chip storage. Reads come out of a
// READ_LAT-deep pipeline; writes honour the byte lanes. A side-band loader
// preloads program images. Accesses beyond DEPTH are dropped or read as zero
// and latch Range_err.
//
// Ports:
//   Clk        system clock, rising edge
//   Reset      asynchronous active-high; clears pipeline and flags, not memory
//   CE/UB/LB   chip enable and byte lane enables, active-low
//   OE/WE      read and write strobes, active-low; WE dominates OE
//   ADDR       20-bit word address
//   Data_in    write data
//   Data_out   read data (holds the last delivered word)
//   Data_oe    high while Data_out carries a freshly delivered read
//   Init_en    loader write strobe, active-high
//   Init_addr  loader word address
//   Init_data  loader word
//   Range_err  sticky flag: a CPU access hit ADDR >= DEPTH
//   Acc_count  wrapping count of accepted CPU reads and writes
module sram_responder #(
    parameter int DEPTH    = 4096,
    parameter int READ_LAT = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CE,
    input  logic        UB,
    input  logic        LB,
    input  logic        OE,
    input  logic        WE,
    input  logic [19:0] ADDR,
    input  logic [15:0] Data_in,
    output logic [15:0] Data_out,
    output logic        Data_oe,
    input  logic        Init_en,
    input  logic [15:0] Init_addr,
    input  logic [15:0] Init_data,
    output logic        Range_err,
    output logic [15:0] Acc_count
);

    localparam int DATA_W = 16;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [20:0] DEPTH_C = 21'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              cpu_wr;
    logic              cpu_rd;
    logic              cpu_acc;
    logic              in_range;
    logic              init_ok;
    logic [AW-1:0]     idx;
    logic [AW-1:0]     init_idx;
    logic [DATA_W-1:0] rd_word;

    logic [READ_LAT-1:0] vld_p;
    logic [DATA_W-1:0]   dat_p [READ_LAT];
    // Set once any read has been delivered since reset, so Data_out can
    // return zero after reset without resetting the data pipeline itself.
    logic                have_out;

    assign cpu_wr   = !CE && !WE;
    assign cpu_rd   = !CE && WE && !OE;
    assign cpu_acc  = cpu_wr || cpu_rd;
    assign in_range = {1'b0, ADDR} < DEPTH_C;
    assign init_ok  = {5'd0, Init_addr} < DEPTH_C;
    assign idx      = ADDR[AW-1:0];
    assign init_idx = Init_addr[AW-1:0];

    // Disabled lanes and out-of-range reads return zero.
    always_comb begin
        rd_word = '0;
        if (in_range) begin
            if (!UB) rd_word[15:8] = mem[idx][15:8];
            if (!LB) rd_word[7:0]  = mem[idx][7:0];
        end
    end

    // Array update: the loader assignment comes last so it wins a collision
    // with a CPU write to the same word.
    always_ff @(posedge Clk) begin
        if (cpu_wr && in_range && !Reset) begin
            if (!UB) mem[idx][15:8] <= Data_in[15:8];
            if (!LB) mem[idx][7:0]  <= Data_in[7:0];
        end
        if (Init_en && init_ok) begin
            mem[init_idx] <= Init_data;
        end
    end

    // Control: valid chain, delivery flag, error flag and access counter.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vld_p     <= '0;
            have_out  <= 1'b0;
            Range_err <= 1'b0;
            Acc_count <= '0;
        end else begin
            // stage 0: request sampled
            vld_p[0] <= cpu_rd;
            // stages 1..READ_LAT-1: shift toward the output
            for (int i = 1; i < READ_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
            if (vld_p[READ_LAT-1]) have_out <= 1'b1;
            if (cpu_acc) begin
                Acc_count <= Acc_count + 16'd1;
                if (!in_range) Range_err <= 1'b1;
            end
        end
    end

    // Data: a stage only loads when its upstream valid is set, so the output
    // stage keeps the last delivered word and discarded reads never surface.
    always_ff @(posedge Clk) begin
        // stage 0: word captured at the sampling edge
        if (cpu_rd) dat_p[0] <= rd_word;
        // stages 1..READ_LAT-1
        for (int i = 1; i < READ_LAT; i++) begin
            if (vld_p[i-1]) dat_p[i] <= dat_p[i-1];
        end
    end

    assign Data_oe  = vld_p[READ_LAT-1];
    assign Data_out = (have_out || vld_p[READ_LAT-1]) ? dat_p[READ_LAT-1] : '0;

endmodule

// File: tb/tb_sram_responder.sv
module tb_sram_responder;

    localparam int LAT = 2;

    logic        Clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst3 = 1'b1;
    logic        CE = 1'b1, UB = 1'b1, LB = 1'b1, OE = 1'b1, WE = 1'b1;
    logic [19:0] ADDR = '0;
    logic [15:0] Data_in = '0;
    logic        Init_en = 1'b0;
    logic [15:0] Init_addr = '0, Init_data = '0;

    logic [15:0] dout, acnt, dout3, acnt3;
    logic        doe, rerr, doe3, rerr3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;
    exp_t sb_q[$];

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    sram_responder #(.DEPTH(4096), .READ_LAT(LAT)) u_dut (
        .Clk(Clk), .Reset(rst), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
        .ADDR(ADDR), .Data_in(Data_in), .Data_out(dout), .Data_oe(doe),
        .Init_en(Init_en), .Init_addr(Init_addr), .Init_data(Init_data),
        .Range_err(rerr), .Acc_count(acnt)
    );

    // Second instance with a deeper pipeline shares the bus but has its own reset.
    sram_responder #(.DEPTH(4096), .READ_LAT(3)) u_dut3 (
        .Clk(Clk), .Reset(rst3), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
        .ADDR(ADDR), .Data_in(Data_in), .Data_out(dout3), .Data_oe(doe3),
        .Init_en(Init_en), .Init_addr(Init_addr), .Init_data(Init_data),
        .Range_err(rerr3), .Acc_count(acnt3)
    );

    // Scoreboard: every delivered read is popped and compared, including the
    // cycle in which it appears; an overdue entry is reported as missing.
    always @(negedge Clk) begin
        if (!rst) begin
            if (doe) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got Data_oe=1 data=%h at cycle %0d, expected no read", dout, cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (dout !== e.data || cyc != e.due) begin
                        errors++;
                        $display("FAIL sb_read: got %h at cycle %0d, expected %h at cycle %0d", dout, cyc, e.data, e.due);
                    end
                end
            end else if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                exp_t e;
                e = sb_q.pop_front();
                checks++;
                errors++;
                $display("FAIL sb_missing: got no read by cycle %0d, expected %h at cycle %0d", cyc, e.data, e.due);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_idle();
        CE = 1'b1; WE = 1'b1; OE = 1'b1; UB = 1'b1; LB = 1'b1;
        Init_en = 1'b0;
    endtask

    task automatic set_cpu(input logic ce, we, oe, ub, lb,
                           input logic [19:0] a, input logic [15:0] d);
        CE = ce; WE = we; OE = oe; UB = ub; LB = lb; ADDR = a; Data_in = d;
    endtask

    task automatic do_read(input logic [19:0] a, input logic ub, lb,
                           input logic [15:0] exp);
        exp_t e;
        set_cpu(1'b0, 1'b1, 1'b0, ub, lb, a, 16'h0);
        Init_en = 1'b0;
        tick();
        e.data = exp;
        e.due  = cyc + LAT - 1;
        sb_q.push_back(e);
    endtask

    task automatic do_write(input logic [19:0] a, input logic ub, lb,
                            input logic [15:0] d);
        set_cpu(1'b0, 1'b0, 1'b1, ub, lb, a, d);
        Init_en = 1'b0;
        tick();
    endtask

    task automatic do_load(input logic [15:0] a, input logic [15:0] d);
        set_idle();
        Init_en = 1'b1; Init_addr = a; Init_data = d;
        tick();
        Init_en = 1'b0;
    endtask

    task automatic drain(input string name);
        set_idle();
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) tick();
        tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d reads outstanding, expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rst3 = 1'b1;
        set_idle();
        repeat (3) tick();
        checks++;
        if (dout !== 16'h0000 || doe !== 1'b0 || rerr !== 1'b0 || acnt !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: got out=%h oe=%b err=%b cnt=%h, expected 0000 0 0 0000", dout, doe, rerr, acnt);
        end
        checks++;
        if (dout3 !== 16'h0000 || doe3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state3: got out=%h oe=%b, expected 0000 0", dout3, doe3);
        end
        rst = 1'b0; rst3 = 1'b0;
        tick();
    endtask

    task automatic test_load_read();
        do_load(16'h0005, 16'h1234);
        do_read(20'h00005, 1'b0, 1'b0, 16'h1234);
        drain("load_read");
        checks++;
        if (acnt !== 16'h0001) begin
            errors++;
            $display("FAIL load_read_count: got %h, expected 0001", acnt);
        end
        checks++;
        if (dout !== 16'h1234 || doe !== 1'b0) begin
            errors++;
            $display("FAIL load_read_hold: got out=%h oe=%b, expected 1234 0", dout, doe);
        end
    endtask

    task automatic test_byte_lanes();
        do_load(16'h0007, 16'hAAAA);
        do_write(20'h00007, 1'b1, 1'b0, 16'h5566);
        do_read(20'h00007, 1'b0, 1'b0, 16'hAA66);
        do_read(20'h00007, 1'b0, 1'b1, 16'hAA00);
        do_read(20'h00007, 1'b1, 1'b0, 16'h0066);
        drain("byte_lanes");
    endtask

    task automatic test_back_to_back();
        logic [15:0] c0, cexp;
        do_load(16'h0003, 16'h3333);
        c0 = acnt;
        set_cpu(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00002, 16'hBEEF);
        tick();
        do_read(20'h00002, 1'b0, 1'b0, 16'hBEEF);
        do_read(20'h00003, 1'b0, 1'b0, 16'h3333);
        do_read(20'h00002, 1'b0, 1'b0, 16'hBEEF);
        drain("back_to_back");
        cexp = c0 + 16'd4;
        checks++;
        if (acnt !== cexp) begin
            errors++;
            $display("FAIL b2b_count: got %h, expected %h", acnt, cexp);
        end
    endtask

    task automatic test_collision();
        set_cpu(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00009, 16'h8888);
        Init_en = 1'b1; Init_addr = 16'h0009; Init_data = 16'h7777;
        tick();
        set_cpu(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h0000B, 16'hBBBB);
        Init_en = 1'b1; Init_addr = 16'h000A; Init_data = 16'hAAAA;
        tick();
        do_read(20'h00009, 1'b0, 1'b0, 16'h7777);
        do_read(20'h0000A, 1'b0, 1'b0, 16'hAAAA);
        do_read(20'h0000B, 1'b0, 1'b0, 16'hBBBB);
        drain("collision");
    endtask

    task automatic test_out_of_range();
        do_load(16'h0000, 16'h0F0F);
        do_load(16'h1005, 16'hDEAD);
        checks++;
        if (rerr !== 1'b0) begin
            errors++;
            $display("FAIL oor_pre: got Range_err=%b, expected 0", rerr);
        end
        do_write(20'h01000, 1'b0, 1'b0, 16'h1111);
        checks++;
        if (rerr !== 1'b1) begin
            errors++;
            $display("FAIL oor_set: got Range_err=%b, expected 1", rerr);
        end
        do_read(20'h01000, 1'b0, 1'b0, 16'h0000);
        do_read(20'h10005, 1'b0, 1'b0, 16'h0000);
        do_read(20'h00005, 1'b0, 1'b0, 16'h1234);
        do_read(20'h00000, 1'b0, 1'b0, 16'h0F0F);
        drain("oor");
        checks++;
        if (rerr !== 1'b1) begin
            errors++;
            $display("FAIL oor_sticky: got Range_err=%b, expected 1", rerr);
        end
    endtask

    task automatic test_reset_mid_read();
        do_load(16'h0010, 16'h1010);
        do_read(20'h00010, 1'b0, 1'b0, 16'h1010);
        rst3 = 1'b1;
        set_idle();
        tick();
        rst3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (doe3 !== 1'b0 || dout3 !== 16'h0000) begin
                errors++;
                $display("FAIL midrst_quiet%0d: got out=%h oe=%b, expected 0000 0", i, dout3, doe3);
            end
            tick();
        end
        do_read(20'h00010, 1'b0, 1'b0, 16'h1010);
        set_idle();
        tick();
        checks++;
        if (doe3 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_early: got oe=%b, expected 0", doe3);
        end
        tick();
        checks++;
        if (doe3 !== 1'b1 || dout3 !== 16'h1010) begin
            errors++;
            $display("FAIL midrst_reread: got out=%h oe=%b, expected 1010 1", dout3, doe3);
        end
        drain("midrst");
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        set_idle();
        tick();
        rst = 1'b0;
        checks++;
        if (acnt !== 16'h0000 || rerr !== 1'b0) begin
            errors++;
            $display("FAIL wrap_reset: got cnt=%h err=%b, expected 0000 0", acnt, rerr);
        end
        set_cpu(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 20'h00000, 16'hFFFF);
        repeat (65535) @(posedge Clk);
        #1;
        set_idle();
        checks++;
        if (acnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_full: got %h, expected ffff", acnt);
        end
        do_write(20'h00000, 1'b1, 1'b1, 16'h0000);
        checks++;
        if (acnt !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_roll: got %h, expected 0000", acnt);
        end
        do_read(20'h00000, 1'b0, 1'b0, 16'h0F0F);
        drain("wrap");
    endtask

    initial begin
        @(negedge Clk);
        test_reset();
        test_load_read();
        test_byte_lanes();
        test_back_to_back();
        test_collision();
        test_out_of_range();
        test_reset_mid_read();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
